// File: rtl/tjmono_hit_assembler.sv
// Rebuilds TJ-Monopix hits from the four-word FIFO groups tagged 00/01/10/11.
// The output register loads 1 clock after the terminator pop. A stalled output blocks further FIFO pops.
module tjmono_hit_assembler #(
  parameter logic [1:0] IDENTYFIER = 2'b00,
  parameter int         CNT_WIDTH  = 16
) (
  input  logic                 BUS_CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 FIFO_EMPTY,
  input  logic [31:0]          FIFO_DATA,
  output logic                 FIFO_READ,
  output logic                 HIT_VALID,
  input  logic                 HIT_READY,
  output logic [5:0]           HIT_COL,
  output logic [8:0]           HIT_ROW,
  output logic [5:0]           HIT_TE,
  output logic [5:0]           HIT_LE,
  output logic                 HIT_NOISE,
  output logic [51:0]          HIT_TS,
  output logic [3:0]           HIT_TOKCNT,
  output logic [CNT_WIDTH-1:0] HIT_CNT,
  output logic [7:0]           SEQ_ERR_CNT,
  output logic [7:0]           ID_ERR_CNT
);

  // The state encoding equals the tag that is expected next.
  localparam logic [1:0] EXP0 = 2'd0;
  localparam logic [1:0] EXP1 = 2'd1;
  localparam logic [1:0] EXP2 = 2'd2;
  localparam logic [1:0] EXP3 = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [83:0]          w_q, w_d;
  logic [83:0]          rec_q, rec_d;
  logic                 hit_vld_q, hit_vld_d;
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [7:0]           seq_err_q, seq_err_d;
  logic [7:0]           id_err_q, id_err_d;

  logic        pop;
  logic        load;
  logic [1:0]  tag;
  logic [27:0] pay;
  logic        id_ok;

  assign tag   = FIFO_DATA[29:28];
  assign pay   = FIFO_DATA[27:0];
  assign id_ok = (FIFO_DATA[31:30] == IDENTYFIER);
  assign pop   = EN & ~FIFO_EMPTY & ~(hit_vld_q & ~HIT_READY) & ~RST;

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    load      = 1'b0;
    seq_err_d = seq_err_q;
    id_err_d  = id_err_q;
    if (pop) begin
      if (!id_ok) begin
        if (id_err_q != 8'hFF) id_err_d = id_err_q + 8'd1;
      end else if (tag == state_q) begin
        state_d = state_q + 2'd1;
        case (tag)
          EXP0:    w_d[27:0]  = pay;
          EXP1:    w_d[55:28] = pay;
          EXP2:    w_d[83:56] = pay;
          default: begin
            load = 1'b1;
            w_d  = '0;
          end
        endcase
      end else begin
        // A misplaced tag-00 word is kept as the start of a new group.
        if (seq_err_q != 8'hFF) seq_err_d = seq_err_q + 8'd1;
        w_d = '0;
        if (tag == EXP0) begin
          w_d[27:0] = pay;
          state_d   = EXP1;
        end else begin
          state_d = EXP0;
        end
      end
    end
  end

  always_comb begin
    hit_vld_d = load | (hit_vld_q & ~HIT_READY);
    rec_d     = load ? w_q : rec_q;
    hit_cnt_d = hit_cnt_q + {{(CNT_WIDTH-1){1'b0}}, load};
  end

  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      state_q   <= EXP0;
      w_q       <= '0;
      rec_q     <= '0;
      hit_vld_q <= 1'b0;
      hit_cnt_q <= '0;
      seq_err_q <= '0;
      id_err_q  <= '0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      rec_q     <= rec_d;
      hit_vld_q <= hit_vld_d;
      hit_cnt_q <= hit_cnt_d;
      seq_err_q <= seq_err_d;
      id_err_q  <= id_err_d;
    end
  end

  assign FIFO_READ   = pop;
  assign HIT_VALID   = hit_vld_q;
  assign HIT_COL     = rec_q[5:0];
  assign HIT_ROW     = rec_q[14:6];
  assign HIT_TE      = rec_q[20:15];
  assign HIT_LE      = rec_q[26:21];
  assign HIT_NOISE   = rec_q[27];
  assign HIT_TS      = rec_q[79:28];
  assign HIT_TOKCNT  = rec_q[83:80];
  assign HIT_CNT     = hit_cnt_q;
  assign SEQ_ERR_CNT = seq_err_q;
  assign ID_ERR_CNT  = id_err_q;

endmodule

// File: tb/tb_tjmono_hit_assembler.sv
// Bench for tjmono_hit_assembler: a FWFT source model feeds the DUT and a scoreboard checks the records.
module tb_tjmono_hit_assembler;

  logic        BUS_CLK = 1'b0;
  logic        RST, EN, FIFO_EMPTY, HIT_READY;
  logic [31:0] FIFO_DATA;
  logic        FIFO_READ, HIT_VALID, HIT_NOISE;
  logic [5:0]  HIT_COL, HIT_TE, HIT_LE;
  logic [8:0]  HIT_ROW;
  logic [51:0] HIT_TS;
  logic [3:0]  HIT_TOKCNT;
  logic [15:0] HIT_CNT;
  logic [7:0]  SEQ_ERR_CNT, ID_ERR_CNT;

  tjmono_hit_assembler #(.IDENTYFIER(2'b00), .CNT_WIDTH(16)) dut (
    .BUS_CLK(BUS_CLK), .RST(RST), .EN(EN), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA),
    .FIFO_READ(FIFO_READ), .HIT_VALID(HIT_VALID), .HIT_READY(HIT_READY),
    .HIT_COL(HIT_COL), .HIT_ROW(HIT_ROW), .HIT_TE(HIT_TE), .HIT_LE(HIT_LE),
    .HIT_NOISE(HIT_NOISE), .HIT_TS(HIT_TS), .HIT_TOKCNT(HIT_TOKCNT), .HIT_CNT(HIT_CNT),
    .SEQ_ERR_CNT(SEQ_ERR_CNT), .ID_ERR_CNT(ID_ERR_CNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  typedef struct packed {
    logic [3:0]  tok;
    logic [51:0] ts;
    logic        noise;
    logic [5:0]  le;
    logic [5:0]  te;
    logic [8:0]  row;
    logic [5:0]  col;
  } hit_t;

  typedef struct {
    logic [27:0] p0, p1, p2;
    hit_t        exp;
  } vec_t;

  vec_t        tbl[6];
  hit_t        exp_q[$];
  logic [31:0] src_q[$];
  int          nchk = 0;
  int          nerr = 0;
  bit          pop_pend = 1'b0;
  bit          stall_prev = 1'b0;
  hit_t        rec_prev;

  function automatic hit_t decode(logic [27:0] p0, logic [27:0] p1, logic [27:0] p2);
    logic [83:0] w;
    hit_t h;
    w       = {p2, p1, p0};
    h.col   = w[5:0];
    h.row   = w[14:6];
    h.te    = w[20:15];
    h.le    = w[26:21];
    h.noise = w[27];
    h.ts    = w[79:28];
    h.tok   = w[83:80];
    return h;
  endfunction

  function automatic hit_t cur_rec();
    return {HIT_TOKCNT, HIT_TS, HIT_NOISE, HIT_LE, HIT_TE, HIT_ROW, HIT_COL};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic push_word(input logic [1:0] id, input logic [1:0] t, input logic [27:0] p);
    src_q.push_back({id, t, p});
  endtask

  task automatic send_group(input logic [27:0] p0, input logic [27:0] p1, input logic [27:0] p2);
    push_word(2'b00, 2'b00, p0);
    push_word(2'b00, 2'b01, p1);
    push_word(2'b00, 2'b10, p2);
    push_word(2'b00, 2'b11, 28'h0);
    exp_q.push_back(decode(p0, p1, p2));
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      done = (src_q.size() == 0) && (exp_q.size() == 0) && !HIT_VALID && FIFO_EMPTY;
    end
    chk(name, done, 1'b1);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    src_q.delete();
    exp_q.delete();
    tick();
    tick();
    RST = 1'b0;
    tick();
  endtask

  initial begin
    hit_t h;
    int   sz;
    bit   found;
    logic [27:0] a, b, c, d, e;

    RST = 1'b1; EN = 1'b1; HIT_READY = 1'b1; FIFO_EMPTY = 1'b1; FIFO_DATA = '0;

    fork
      // FWFT source: pops follow FIFO_READ as sampled before the edge.
      forever begin
        @(posedge BUS_CLK);
        #1;
        if (pop_pend && src_q.size() > 0) void'(src_q.pop_front());
        FIFO_EMPTY = (src_q.size() == 0);
        FIFO_DATA  = FIFO_EMPTY ? 32'h0 : src_q[0];
      end
      forever begin
        @(negedge BUS_CLK);
        pop_pend = FIFO_READ;
        if (!RST) begin
          if (HIT_VALID && HIT_READY) begin
            if (exp_q.size() == 0) chk("unexpected_record", 1'b1, 1'b0);
            else chk("record", cur_rec(), exp_q.pop_front());
          end
          if (stall_prev && HIT_VALID) chk("stall_fields", cur_rec(), rec_prev);
          if (HIT_VALID && !HIT_READY) chk("stall_read", FIFO_READ, 1'b0);
          stall_prev = HIT_VALID && !HIT_READY;
          rec_prev   = cur_rec();
        end else begin
          stall_prev = 1'b0;
        end
      end
    join_none

    do_reset();
    chk("rst_valid", HIT_VALID, 1'b0);
    chk("rst_fields", cur_rec(), '0);
    chk("rst_cnts", {HIT_CNT, SEQ_ERR_CNT, ID_ERR_CNT}, '0);

    // Vector 0 is worked out by hand from the field mapping; the rest are random.
    tbl[0].p0 = 28'h0123456; tbl[0].p1 = 28'hABCDEF0; tbl[0].p2 = 28'h5A5A5A5;
    tbl[0].exp = '{tok: 4'h5, ts: 52'hA5A5A5ABCDEF0, noise: 1'b0, le: 6'h00,
                   te: 6'h24, row: 9'h0D1, col: 6'h16};
    for (int i = 1; i < 6; i++) begin
      tbl[i].p0  = 28'($urandom);
      tbl[i].p1  = 28'($urandom);
      tbl[i].p2  = 28'($urandom);
      tbl[i].exp = decode(tbl[i].p0, tbl[i].p1, tbl[i].p2);
    end
    tbl[1].p0[27] = 1'b1;
    tbl[1].exp.noise = 1'b1;

    // Terminator pop to HIT_VALID latency on the first vector.
    send_group(tbl[0].p0, tbl[0].p1, tbl[0].p2);
    found = 1'b0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      @(negedge BUS_CLK);
      if (FIFO_READ && FIFO_DATA[29:28] == 2'b11) found = 1'b1;
    end
    chk("t1_term_pop", found, 1'b1);
    chk("t1_vld_before", HIT_VALID, 1'b0);
    @(negedge BUS_CLK);
    chk("t1_vld_latency", HIT_VALID, 1'b1);
    @(negedge BUS_CLK);
    chk("t1_single_pulse", HIT_VALID, 1'b0);
    wait_idle("t1_idle", 30);
    chk("t1_fields", cur_rec(), tbl[0].exp);
    chk("t1_hit_cnt", HIT_CNT, 16'd1);

    for (int i = 1; i < 6; i++) begin
      send_group(tbl[i].p0, tbl[i].p1, tbl[i].p2);
      wait_idle("tbl_idle", 30);
      chk("tbl_fields", cur_rec(), tbl[i].exp);
      chk("tbl_hit_cnt", HIT_CNT, 16'(i + 1));
    end

    // EN low mid-record holds the partial group.
    do_reset();
    send_group(28'h1111111, 28'h2222222, 28'h3333333);
    for (int cyc = 0; cyc < 20 && src_q.size() > 2; cyc++) tick();
    EN = 1'b0;
    tick();
    sz = src_q.size();
    repeat (6) tick();
    chk("en_hold_pops", src_q.size(), sz);
    chk("en_hold_valid", HIT_VALID, 1'b0);
    EN = 1'b1;
    wait_idle("en_idle", 30);
    chk("en_hit_cnt", HIT_CNT, 16'd1);

    // Stalled sink with three queued records.
    do_reset();
    HIT_READY = 1'b0;
    for (int i = 0; i < 3; i++) send_group(tbl[i+2].p0, tbl[i+2].p1, tbl[i+2].p2);
    found = 1'b0;
    for (int cyc = 0; cyc < 30 && !found; cyc++) begin
      tick();
      found = HIT_VALID;
    end
    chk("stall_first_vld", found, 1'b1);
    repeat (20) tick();
    chk("stall_hit_cnt", HIT_CNT, 16'd1);
    chk("stall_src_left", src_q.size(), 8);
    HIT_READY = 1'b1;
    wait_idle("stall_idle", 60);
    chk("stall_hit_cnt_end", HIT_CNT, 16'd3);

    // Sequence errors: a misplaced tag 00 restarts the group; other tags drop it.
    do_reset();
    a = 28'hAAAAAAA; b = 28'hBBBBBBB; c = 28'h0C0FFEE; d = 28'hD00D00D; e = 28'hE1E2E3E;
    push_word(2'b00, 2'b00, a);
    push_word(2'b00, 2'b01, b);
    push_word(2'b00, 2'b00, c);
    push_word(2'b00, 2'b01, d);
    push_word(2'b00, 2'b10, e);
    push_word(2'b00, 2'b11, 28'h0);
    exp_q.push_back(decode(c, d, e));
    wait_idle("seq_idle", 40);
    chk("seq_err_cnt", SEQ_ERR_CNT, 8'd1);
    chk("seq_hit_cnt", HIT_CNT, 16'd1);
    push_word(2'b00, 2'b00, a);
    push_word(2'b00, 2'b10, b);
    push_word(2'b00, 2'b11, 28'h0);
    send_group(e, d, c);
    wait_idle("seq2_idle", 40);
    chk("seq2_err_cnt", SEQ_ERR_CNT, 8'd3);
    chk("seq2_hit_cnt", HIT_CNT, 16'd2);

    // A bad identifier word is dropped without disturbing the group.
    do_reset();
    push_word(2'b00, 2'b00, a);
    push_word(2'b00, 2'b01, b);
    push_word(2'b11, 2'b10, 28'hFFFFFFF);
    push_word(2'b00, 2'b10, e);
    push_word(2'b00, 2'b11, 28'h0);
    exp_q.push_back(decode(a, b, e));
    wait_idle("id_idle", 40);
    chk("id_err_cnt", ID_ERR_CNT, 8'd1);
    chk("id_seq_cnt", SEQ_ERR_CNT, 8'd0);
    chk("id_hit_cnt", HIT_CNT, 16'd1);

    // Saturation of both error counters.
    do_reset();
    for (int i = 0; i < 300; i++) push_word(2'b00, 2'b01, 28'(i));
    wait_idle("sat_seq_idle", 400);
    chk("sat_seq_cnt", SEQ_ERR_CNT, 8'd255);
    chk("sat_seq_hits", HIT_CNT, 16'd0);
    for (int i = 0; i < 260; i++) push_word(2'b10, 2'b00, 28'(i));
    wait_idle("sat_id_idle", 400);
    chk("sat_id_cnt", ID_ERR_CNT, 8'd255);
    chk("sat_id_seq", SEQ_ERR_CNT, 8'd255);

    // Reset in the middle of a group, with a record already delivered.
    do_reset();
    send_group(a, b, c);
    wait_idle("rst_pre_idle", 30);
    push_word(2'b00, 2'b00, d);
    push_word(2'b00, 2'b01, e);
    for (int cyc = 0; cyc < 20 && src_q.size() > 0; cyc++) tick();
    tick();
    RST = 1'b1;
    push_word(2'b00, 2'b10, a);
    tick();
    #2;
    chk("rst_src_nonempty", FIFO_EMPTY, 1'b0);
    chk("rst_no_read", FIFO_READ, 1'b0);
    src_q.delete();
    exp_q.delete();
    tick();
    RST = 1'b0;
    tick();
    chk("rst2_valid", HIT_VALID, 1'b0);
    chk("rst2_fields", cur_rec(), '0);
    chk("rst2_cnts", {HIT_CNT, SEQ_ERR_CNT, ID_ERR_CNT}, '0);
    send_group(c, b, a);
    wait_idle("rst2_idle", 30);
    h = decode(c, b, a);
    chk("rst2_record", cur_rec(), h);
    chk("rst2_hit_cnt", HIT_CNT, 16'd1);
    chk("rst2_seq_cnt", SEQ_ERR_CNT, 8'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
